fb_pixel_writer: RTL and testbench
==================================

Name: fb_pixel_writer

Overview:
- Consumes the (x, y, palette) pixel stream produced by the painter stages (background fill, sprite painters) and turns it into framebuffer RAM word writes.
- Range-checks each pixel, computes its word address and lane, and coalesces consecutive pixels that fall in the same RAM word into one masked write.
- Owns the double-buffer select: painters always write the back buffer; a swap request flips front/back once every in-flight pixel has been written.

Parameters:
COOR_WIDTH, 12, width of the x/y coordinates
FB_WIDTH, 1280, framebuffer width in pixels; must be a multiple of PIXELS_PER_WORD
FB_HEIGHT, 300, framebuffer height in pixels
PIXELS_PER_WORD, 8, pixels per RAM word; must be a power of two
ADDR_WIDTH, 16, word address width per buffer; 2^ADDR_WIDTH >= FB_WIDTH*FB_HEIGHT/PIXELS_PER_WORD

Ports:
clk_33m  in  1  system clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  pixel qualifier; the block takes one pixel per cycle and never stalls
in_x  in  COOR_WIDTH  pixel column
in_y  in  COOR_WIDTH  pixel row
in_palette  in  3  palette index; 0 is transparent
flush  in  1  pulse: write out the pending word once the pipeline drains
swap_req  in  1  pulse: request a front/back buffer swap
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_WIDTH+1  MSB selects the buffer, low bits give the word index
ram_wdata  out  3*PIXELS_PER_WORD  lane i occupies bits [3i+2:3i]
ram_wmask  out  PIXELS_PER_WORD  per-lane write enable
front_buf  out  1  buffer currently being displayed
idle  out  1  pipeline empty, no pending word, no flush or swap outstanding
dropped  out  1  one-cycle pulse when an out-of-range pixel is discarded

Behaviour:
- Reset (async, rst=1): all pipeline valids cleared; pending word discarded with no write; flush_pend=0, swap_pend=0, front_buf=0, ram_we=0, ram_addr=0, ram_wdata=0, ram_wmask=0, dropped=0, idle=1.
- S1, register input: a pixel is kept only if in_valid, in_x<FB_WIDTH, in_y<FB_HEIGHT and in_palette!=0.
  - Out-of-range pixel: dropped pulses 1 cycle later.
  - Transparent pixel: discarded silently.
- S2, address: word = in_y*(FB_WIDTH/PIXELS_PER_WORD) + in_x/PIXELS_PER_WORD, lane = in_x mod PIXELS_PER_WORD.
  - The multiply is registered.
  - No truncation below ADDR_WIDTH.
- S3, coalesce (one pending word: addr, data, mask, valid).
  - S2 valid, pending valid, same word: merge the lane; a later pixel overwrites the same lane; no write.
  - S2 valid, different word or pending empty: emit the pending word (if valid) as a registered RAM write, then load the new pixel (mask has one bit set).
  - At most one RAM write per cycle. ram_we is registered: the write appears the cycle after S3 decides.
- Write address MSB = ~front_buf (always the back buffer), latched when the pixel enters S2.
- Flush:
  - flush sets flush_pend.
  - When S1 and S2 are empty and flush_pend=1: emit the pending word (if any) and clear flush_pend.
  - Pixels arriving meanwhile still merge; flush_pend stays set until the pipeline is empty.
- Swap:
  - swap_req sets swap_pend and implies a flush.
  - front_buf toggles in the first cycle where S1, S2 and the pending word are empty and in_valid=0. swap_pend clears in that same cycle.
  - A swap_req while swap_pend=1 is absorbed (single toggle).
- Simultaneous flush and swap_req: both are served by the same drain.
- End-to-end latency, pixel to RAM write: minimum 4 cycles after in_valid (S1, S2, S3 displacement, output register). Otherwise unbounded until the word is displaced or flushed.
- idle is combinational from the state above. Painters hold off starting the next frame until idle=1 after a swap.

Decomposition:
- Package fb_pkg:
  - PALETTE_WIDTH=3
  - PALETTE_TRANSPARENT=0
  - PALETTE_WHITE=7
  - pixel_t struct {x, y, palette}
  - fb_wr_t struct {addr, data, mask}
- Sub-module fb_word_merger: the S3 pending-word register, the merge/emit logic and the output register. Top level keeps S1/S2 and the flush/swap control.

Test Plan:
- Full background fill, 1280x300 palette 7 on consecutive cycles, then flush: exactly 48000 writes; addr 0x10000..0x1BB7F in order; every write has wdata 0xFFFFFF and wmask 0xFF; idle=1 afterwards.
- Pixels (3,0,p5), (3,0,p2), (4,0,p1), then flush: one write, addr 0x10000, mask 0x18, lane3=2, lane4=1.
- Pixels (0,0,p7) then (8,0,p7): first write addr 0x10000 mask 0x01 appears 4 cycles after the second pixel's in_valid; flush gives addr 0x10001 mask 0x01.
- Inputs x=1280,y=0 and x=0,y=300: two dropped pulses, no writes. Palette 0 input: no write and no dropped pulse.
- swap_req asserted while 3 pixels are in flight: all 3 are written with MSB=1 before front_buf goes to 1; the next pixel (0,0,p7) is written at addr 0x00000.
- rst asserted mid-stream with a pending word: outputs go to 0 immediately; no write of the pending word; front_buf=0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and constants for the framebuffer pixel writer.
package fb_pkg;

  localparam int PALETTE_WIDTH = 3;
  localparam logic [PALETTE_WIDTH-1:0] PALETTE_TRANSPARENT = 3'd0;
  localparam logic [PALETTE_WIDTH-1:0] PALETTE_WHITE       = 3'd7;

  // Default geometry; the struct layouts below are sized from these.
  localparam int COOR_WIDTH_DEF      = 12;
  localparam int PIXELS_PER_WORD_DEF = 8;
  localparam int ADDR_WIDTH_DEF      = 16;

  typedef struct packed {
    logic [COOR_WIDTH_DEF-1:0] x;
    logic [COOR_WIDTH_DEF-1:0] y;
    logic [PALETTE_WIDTH-1:0]  palette;
  } pixel_t;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF:0]                        addr;
    logic [PALETTE_WIDTH*PIXELS_PER_WORD_DEF-1:0]   data;
    logic [PIXELS_PER_WORD_DEF-1:0]                 mask;
  } fb_wr_t;

endpackage

// File: rtl/fb_word_merger.sv
// Pending-word coalescer: merges same-word pixels and emits displaced or
// flushed words through a registered RAM write port.
module fb_word_merger
  import fb_pkg::*;
#(
  parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
  localparam int LANE_W         = $clog2(PIXELS_PER_WORD)
) (
  input  logic                                  clk_33m,
  input  logic                                  rst,
  input  logic                                  pix_valid,
  input  logic [ADDR_WIDTH:0]                   pix_addr,
  input  logic [LANE_W-1:0]                     pix_lane,
  input  logic [PALETTE_WIDTH-1:0]              pix_palette,
  input  logic                                  flush_emit,
  output logic                                  pend_valid,
  output logic                                  ram_we,
  output logic [ADDR_WIDTH:0]                   ram_addr,
  output logic [PALETTE_WIDTH*PIXELS_PER_WORD-1:0] ram_wdata,
  output logic [PIXELS_PER_WORD-1:0]            ram_wmask
);

  fb_wr_t pend_reg, pend_next;
  fb_wr_t out_reg, out_next;
  logic   pend_valid_reg, pend_valid_next;
  logic   we_reg, we_next;
  logic   same_word;

  logic [PIXELS_PER_WORD-1:0]               lane_hot;
  logic [PALETTE_WIDTH*PIXELS_PER_WORD-1:0] merged_data;
  logic [PALETTE_WIDTH*PIXELS_PER_WORD-1:0] fresh_data;

  genvar gi;
  generate
    for (gi = 0; gi < PIXELS_PER_WORD; gi++) begin : g_lane
      assign lane_hot[gi] = (pix_lane == LANE_W'(gi));
      assign merged_data[gi*PALETTE_WIDTH +: PALETTE_WIDTH] =
        lane_hot[gi] ? pix_palette : pend_reg.data[gi*PALETTE_WIDTH +: PALETTE_WIDTH];
      assign fresh_data[gi*PALETTE_WIDTH +: PALETTE_WIDTH] =
        lane_hot[gi] ? pix_palette : '0;
    end
  endgenerate

  // The address includes the buffer bit, so words never merge across a swap.
  assign same_word = pend_valid_reg && (pend_reg.addr == pix_addr);

  always_comb begin
    pend_next       = pend_reg;
    pend_valid_next = pend_valid_reg;
    out_next        = out_reg;
    we_next         = 1'b0;
    if (pix_valid) begin
      if (same_word) begin
        pend_next.data = merged_data;
        pend_next.mask = pend_reg.mask | lane_hot;
      end else begin
        if (pend_valid_reg) begin
          out_next = pend_reg;
          we_next  = 1'b1;
        end
        pend_next.addr  = pix_addr;
        pend_next.data  = fresh_data;
        pend_next.mask  = lane_hot;
        pend_valid_next = 1'b1;
      end
    end else if (flush_emit && pend_valid_reg) begin
      out_next        = pend_reg;
      we_next         = 1'b1;
      pend_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      pend_reg       <= '0;
      pend_valid_reg <= 1'b0;
      out_reg        <= '0;
      we_reg         <= 1'b0;
    end else begin
      pend_reg       <= pend_next;
      pend_valid_reg <= pend_valid_next;
      out_reg        <= out_next;
      we_reg         <= we_next;
    end
  end

  assign pend_valid = pend_valid_reg;
  assign ram_we     = we_reg;
  assign ram_addr   = out_reg.addr;
  assign ram_wdata  = out_reg.data;
  assign ram_wmask  = out_reg.mask;

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel stream to framebuffer word writes: range check, address pipeline,
// flush and double-buffer swap control around the word merger.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int COOR_WIDTH      = COOR_WIDTH_DEF,
  parameter int FB_WIDTH        = 1280,
  parameter int FB_HEIGHT       = 300,
  parameter int PIXELS_PER_WORD = PIXELS_PER_WORD_DEF,
  parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF
) (
  input  logic                                     clk_33m,
  input  logic                                     rst,
  input  logic                                     in_valid,
  input  logic [COOR_WIDTH-1:0]                    in_x,
  input  logic [COOR_WIDTH-1:0]                    in_y,
  input  logic [PALETTE_WIDTH-1:0]                 in_palette,
  input  logic                                     flush,
  input  logic                                     swap_req,
  output logic                                     ram_we,
  output logic [ADDR_WIDTH:0]                      ram_addr,
  output logic [PALETTE_WIDTH*PIXELS_PER_WORD-1:0] ram_wdata,
  output logic [PIXELS_PER_WORD-1:0]               ram_wmask,
  output logic                                     front_buf,
  output logic                                     idle,
  output logic                                     dropped
);

  localparam int LANE_W         = $clog2(PIXELS_PER_WORD);
  localparam int WORDS_PER_LINE = FB_WIDTH / PIXELS_PER_WORD;
  localparam logic [COOR_WIDTH-1:0] X_LIMIT = COOR_WIDTH'(FB_WIDTH);
  localparam logic [COOR_WIDTH-1:0] Y_LIMIT = COOR_WIDTH'(FB_HEIGHT);

  pixel_t s1_pix_reg;
  logic   s1_valid_reg, dropped_reg, in_range;

  logic                     mul_valid_reg, mul_buf_reg;
  logic [ADDR_WIDTH-1:0]    mul_row_reg, mul_col_reg;
  logic [LANE_W-1:0]        mul_lane_reg;
  logic [PALETTE_WIDTH-1:0] mul_pal_reg;

  logic                     s2_valid_reg;
  logic [ADDR_WIDTH:0]      s2_addr_reg;
  logic [LANE_W-1:0]        s2_lane_reg;
  logic [PALETTE_WIDTH-1:0] s2_pal_reg;

  logic flush_pend_reg, flush_pend_next;
  logic swap_pend_reg, swap_pend_next;
  logic front_buf_reg, front_buf_next;
  logic drained, flush_emit, do_swap, pend_valid;

  assign in_range = (in_x < X_LIMIT) && (in_y < Y_LIMIT);

  // S1 register, then S2 as a registered row multiply followed by the word add.
  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      s1_valid_reg  <= 1'b0;
      s1_pix_reg    <= '0;
      dropped_reg   <= 1'b0;
      mul_valid_reg <= 1'b0;
      mul_buf_reg   <= 1'b0;
      mul_row_reg   <= '0;
      mul_col_reg   <= '0;
      mul_lane_reg  <= '0;
      mul_pal_reg   <= '0;
      s2_valid_reg  <= 1'b0;
      s2_addr_reg   <= '0;
      s2_lane_reg   <= '0;
      s2_pal_reg    <= '0;
    end else begin
      s1_valid_reg       <= in_valid && in_range && (in_palette != PALETTE_TRANSPARENT);
      dropped_reg        <= in_valid && !in_range;
      s1_pix_reg.x       <= in_x;
      s1_pix_reg.y       <= in_y;
      s1_pix_reg.palette <= in_palette;
      mul_valid_reg      <= s1_valid_reg;
      mul_buf_reg        <= ~front_buf_reg;
      mul_row_reg        <= ADDR_WIDTH'(s1_pix_reg.y) * ADDR_WIDTH'(WORDS_PER_LINE);
      mul_col_reg        <= ADDR_WIDTH'(s1_pix_reg.x >> LANE_W);
      mul_lane_reg       <= s1_pix_reg.x[LANE_W-1:0];
      mul_pal_reg        <= s1_pix_reg.palette;
      s2_valid_reg       <= mul_valid_reg;
      s2_addr_reg        <= {mul_buf_reg, mul_row_reg + mul_col_reg};
      s2_lane_reg        <= mul_lane_reg;
      s2_pal_reg         <= mul_pal_reg;
    end
  end

  assign drained    = !s1_valid_reg && !mul_valid_reg && !s2_valid_reg;
  assign flush_emit = drained && (flush_pend_reg || swap_pend_reg);
  assign do_swap    = swap_pend_reg && drained && !pend_valid && !in_valid;

  always_comb begin
    flush_pend_next = flush_pend_reg;
    swap_pend_next  = swap_pend_reg;
    front_buf_next  = front_buf_reg;
    if (flush_emit) flush_pend_next = 1'b0;
    if (flush || swap_req) flush_pend_next = 1'b1;
    if (do_swap) begin
      swap_pend_next = 1'b0;
      front_buf_next = ~front_buf_reg;
    end else if (swap_req) begin
      swap_pend_next = 1'b1;
    end
  end

  always_ff @(posedge clk_33m or posedge rst) begin
    if (rst) begin
      flush_pend_reg <= 1'b0;
      swap_pend_reg  <= 1'b0;
      front_buf_reg  <= 1'b0;
    end else begin
      flush_pend_reg <= flush_pend_next;
      swap_pend_reg  <= swap_pend_next;
      front_buf_reg  <= front_buf_next;
    end
  end

  fb_word_merger #(
    .PIXELS_PER_WORD(PIXELS_PER_WORD),
    .ADDR_WIDTH     (ADDR_WIDTH)
  ) u_merger (
    .clk_33m    (clk_33m),
    .rst        (rst),
    .pix_valid  (s2_valid_reg),
    .pix_addr   (s2_addr_reg),
    .pix_lane   (s2_lane_reg),
    .pix_palette(s2_pal_reg),
    .flush_emit (flush_emit),
    .pend_valid (pend_valid),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wmask  (ram_wmask)
  );

  assign front_buf = front_buf_reg;
  assign dropped   = dropped_reg;
  assign idle      = drained && !pend_valid && !flush_pend_reg && !swap_pend_reg;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: merging, latency, drops, fill, swap, reset.
module tb_fb_pixel_writer;
  import fb_pkg::*;

  logic        clk_33m = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [11:0] in_x = '0;
  logic [11:0] in_y = '0;
  logic [2:0]  in_palette = '0;
  logic        flush = 1'b0;
  logic        swap_req = 1'b0;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [23:0] ram_wdata;
  logic [7:0]  ram_wmask;
  logic        front_buf, idle, dropped;

  fb_pixel_writer dut (
    .clk_33m   (clk_33m),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_palette(in_palette),
    .flush     (flush),
    .swap_req  (swap_req),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wmask (ram_wmask),
    .front_buf (front_buf),
    .idle      (idle),
    .dropped   (dropped)
  );

  always #5 clk_33m = ~clk_33m;

  typedef struct {
    logic [16:0] addr;
    logic [23:0] data;
    logic [7:0]  mask;
    int          cyc;
    logic        fb;
  } wr_rec_t;

  wr_rec_t wr_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int drop_cnt = 0;

  always @(posedge clk_33m) cyc <= cyc + 1;

  always @(negedge clk_33m) begin
    if (ram_we) begin
      wr_q.push_back('{ram_addr, ram_wdata, ram_wmask, cyc, front_buf});
      $display("write addr=%05h data=%06h mask=%02h cyc=%0d front=%0b",
               ram_addr, ram_wdata, ram_wmask, cyc, front_buf);
    end
    if (dropped) drop_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int x, input int y, input int p,
                       input logic f, input logic s);
    @(negedge clk_33m);
    in_valid   = v;
    in_x       = 12'(x);
    in_y       = 12'(y);
    in_palette = 3'(p);
    flush      = f;
    swap_req   = s;
  endtask

  task automatic pix(input int x, input int y, input int p);
    drive(1'b1, x, y, p, 1'b0, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    nop(1);
    while (!idle && n < budget) begin
      nop(1);
      n++;
    end
    check("idle_wait", 32'(idle), 32'd1);
    nop(2);
  endtask

  task automatic check_wr(input int idx, input logic [16:0] a, input logic [23:0] d,
                          input logic [7:0] m, input string tag);
    if (idx < wr_q.size()) begin
      check({tag, "_addr"}, 32'(wr_q[idx].addr), 32'(a));
      check({tag, "_data"}, 32'(wr_q[idx].data), 32'(d));
      check({tag, "_mask"}, 32'(wr_q[idx].mask), 32'(m));
    end else begin
      check({tag, "_missing"}, 32'(wr_q.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int base, t0, d0, bad;

    // Reset state
    repeat (2) @(negedge clk_33m);
    check("rst_we", 32'(ram_we), 32'd0);
    check("rst_addr", 32'(ram_addr), 32'd0);
    check("rst_wdata", 32'(ram_wdata), 32'd0);
    check("rst_wmask", 32'(ram_wmask), 32'd0);
    check("rst_front", 32'(front_buf), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_dropped", 32'(dropped), 32'd0);
    rst = 1'b0;
    nop(2);

    // Same-word merge with lane overwrite
    base = wr_q.size();
    pix(3, 0, 5);
    pix(3, 0, 2);
    pix(4, 0, 1);
    do_flush();
    wait_idle(50);
    check("merge_count", 32'(wr_q.size() - base), 32'd1);
    check_wr(base, 17'h10000, 24'h001400, 8'h18, "merge");

    // Displacement latency
    base = wr_q.size();
    pix(0, 0, 7);
    pix(8, 0, 7);
    t0 = cyc;
    nop(6);
    check("lat_count", 32'(wr_q.size() - base), 32'd1);
    check_wr(base, 17'h10000, 24'h000007, 8'h01, "lat_first");
    if (wr_q.size() > base) check("lat_cycles", 32'(wr_q[base].cyc - t0), 32'd4);
    do_flush();
    wait_idle(50);
    check("lat_flush_count", 32'(wr_q.size() - base), 32'd2);
    check_wr(base + 1, 17'h10001, 24'h000007, 8'h01, "lat_second");

    // Out-of-range and transparent pixels
    base = wr_q.size();
    d0 = drop_cnt;
    pix(1280, 0, 7);
    pix(0, 300, 7);
    check("drop_pulse_x", 32'(dropped), 32'd1);
    pix(5, 5, 0);
    check("drop_pulse_y", 32'(dropped), 32'd1);
    nop(1);
    check("drop_transparent", 32'(dropped), 32'd0);
    nop(6);
    check("drop_count", 32'(drop_cnt - d0), 32'd2);
    check("drop_no_write", 32'(wr_q.size() - base), 32'd0);
    check("drop_idle", 32'(idle), 32'd1);

    // Last pixel of the frame
    base = wr_q.size();
    pix(1279, 299, 7);
    do_flush();
    wait_idle(50);
    check("corner_count", 32'(wr_q.size() - base), 32'd1);
    check_wr(base, 17'h1BB7F, 24'hE00000, 8'h80, "corner");

    // Background fill of the first four rows
    base = wr_q.size();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 1280; x++) pix(x, y, 7);
    do_flush();
    wait_idle(100);
    check("fill_count", 32'(wr_q.size() - base), 32'd640);
    bad = 0;
    for (int i = 0; i < 640 && base + i < wr_q.size(); i++) begin
      if (wr_q[base+i].addr !== 17'(32'h10000 + i) || wr_q[base+i].data !== 24'hFFFFFF ||
          wr_q[base+i].mask !== 8'hFF)
        bad++;
    end
    check("fill_bad_words", 32'(bad), 32'd0);

    // Swap with three pixels in flight
    base = wr_q.size();
    pix(0, 0, 7);
    pix(16, 0, 7);
    pix(24, 0, 7);
    drive(1'b0, 0, 0, 0, 1'b0, 1'b1);
    check("swap_front_hold", 32'(front_buf), 32'd0);
    wait_idle(50);
    check("swap_count", 32'(wr_q.size() - base), 32'd3);
    check_wr(base, 17'h10000, 24'h000007, 8'h01, "swap_w0");
    check_wr(base + 1, 17'h10002, 24'h000007, 8'h01, "swap_w1");
    check_wr(base + 2, 17'h10003, 24'h000007, 8'h01, "swap_w2");
    bad = 0;
    for (int i = base; i < wr_q.size(); i++) if (wr_q[i].fb !== 1'b0) bad++;
    check("swap_writes_before_toggle", 32'(bad), 32'd0);
    check("swap_front_after", 32'(front_buf), 32'd1);
    base = wr_q.size();
    pix(0, 0, 7);
    do_flush();
    wait_idle(50);
    check("post_swap_count", 32'(wr_q.size() - base), 32'd1);
    check_wr(base, 17'h00000, 24'h000007, 8'h01, "post_swap");

    // Asynchronous reset with a pending word
    pix(5, 1, 3);
    nop(5);
    check("pre_rst_busy", 32'(idle), 32'd0);
    base = wr_q.size();
    @(negedge clk_33m);
    rst = 1'b1;
    #1;
    check("arst_we", 32'(ram_we), 32'd0);
    check("arst_wdata", 32'(ram_wdata), 32'd0);
    check("arst_wmask", 32'(ram_wmask), 32'd0);
    check("arst_front", 32'(front_buf), 32'd0);
    check("arst_idle", 32'(idle), 32'd1);
    nop(2);
    rst = 1'b0;
    do_flush();
    wait_idle(50);
    nop(4);
    check("arst_no_write", 32'(wr_q.size() - base), 32'd0);
    check("arst_front_hold", 32'(front_buf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
